c3aibadapt_cmn_clksel_ctrl: RTL and testbench

//  Sequencer that drives the select input of the 2:1 adapter clock mux.
//  It takes an asynchronous clock-select request and synchronizes it. It then

---
 rtl/c3aibadapt_cmn_pkg.sv | 16 +
 rtl/c3aibadapt_cmn_bitsync.sv | 29 ++
 rtl/c3aibadapt_cmn_clksel_ctrl.sv | 122 ++++++++++++
 tb/tb_c3aibadapt_cmn_clksel_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/c3aibadapt_cmn_pkg.sv
// rtl/c3aibadapt_cmn_pkg.sv - shared encodings and defaults for the adapter common blocks
package c3aibadapt_cmn_pkg;

  typedef logic [2:0] clksel_state_t;

  localparam clksel_state_t CLKSEL_STARTUP  = 3'd0;
  localparam clksel_state_t CLKSEL_IDLE     = 3'd1;
  localparam clksel_state_t CLKSEL_GATE_OFF = 3'd2;
  localparam clksel_state_t CLKSEL_SWITCH   = 3'd3;
  localparam clksel_state_t CLKSEL_SETTLE   = 3'd4;
  localparam clksel_state_t CLKSEL_GATE_ON  = 3'd5;

  localparam int CLKSEL_GATE_CYC_DEF   = 4;
  localparam int CLKSEL_SETTLE_CYC_DEF = 4;

endpackage

// File: rtl/c3aibadapt_cmn_bitsync.sv
// rtl/c3aibadapt_cmn_bitsync.sv - multi-stage single-bit synchronizer with configurable reset value
module c3aibadapt_cmn_bitsync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/c3aibadapt_cmn_clksel_ctrl.sv
// rtl/c3aibadapt_cmn_clksel_ctrl.sv - gate-off/switch/settle/gate-on sequencer for the adapter clock mux select
module c3aibadapt_cmn_clksel_ctrl
  import c3aibadapt_cmn_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   GATE_CYC    = CLKSEL_GATE_CYC_DEF,
  parameter int   SETTLE_CYC  = CLKSEL_SETTLE_CYC_DEF,
  parameter logic RST_SEL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sel_req,
  output logic clk_sel,
  output logic clk_gate_en,
  output logic sw_busy,
  output logic sw_done
);

  localparam int CNT_MAX = (GATE_CYC > SETTLE_CYC) ? GATE_CYC : SETTLE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] GATE_LAST   = CNT_W'(GATE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_SAT     = CNT_W'(CNT_MAX);

  logic          req_s;
  clksel_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic          clk_sel_q, clk_sel_d;
  logic          gate_en_q, gate_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  c3aibadapt_cmn_bitsync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (RST_SEL)
  ) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (sel_req),
    .q   (req_s)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clk_sel_d = clk_sel_q;
    gate_en_d = gate_en_q;
    done_d    = 1'b0;
    cnt_inc   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
    case (state_q)
      CLKSEL_STARTUP: begin
        gate_en_d = 1'b0;
        if (cnt_q == SETTLE_LAST) state_d = CLKSEL_GATE_ON;
        else                      cnt_d   = cnt_inc;
      end
      CLKSEL_IDLE: begin
        gate_en_d = 1'b1;
        if (req_s != clk_sel_q) begin
          state_d   = CLKSEL_GATE_OFF;
          cnt_d     = '0;
          gate_en_d = 1'b0;
        end
      end
      CLKSEL_GATE_OFF: begin
        gate_en_d = 1'b0;
        // Toggle lands on the edge entering SWITCH so the new select is held for that whole cycle.
        if (cnt_q == GATE_LAST) begin
          state_d   = CLKSEL_SWITCH;
          clk_sel_d = ~clk_sel_q;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      CLKSEL_SWITCH: begin
        gate_en_d = 1'b0;
        cnt_d     = '0;
        state_d   = CLKSEL_SETTLE;
      end
      CLKSEL_SETTLE: begin
        gate_en_d = 1'b0;
        if (cnt_q == SETTLE_LAST) state_d = CLKSEL_GATE_ON;
        else                      cnt_d   = cnt_inc;
      end
      CLKSEL_GATE_ON: begin
        gate_en_d = 1'b1;
        done_d    = 1'b1;
        state_d   = CLKSEL_IDLE;
      end
      default: begin
        state_d   = CLKSEL_STARTUP;
        cnt_d     = '0;
        gate_en_d = 1'b0;
      end
    endcase
    // Covers both the entry edge and the GATE_ON->IDLE edge so busy brackets the gate-low window.
    busy_d = (state_d != CLKSEL_IDLE) || (state_q != CLKSEL_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLKSEL_STARTUP;
      cnt_q     <= '0;
      clk_sel_q <= RST_SEL;
      gate_en_q <= 1'b0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clk_sel_q <= clk_sel_d;
      gate_en_q <= gate_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign clk_sel     = clk_sel_q;
  assign clk_gate_en = gate_en_q;
  assign sw_busy     = busy_q;
  assign sw_done     = done_q;

endmodule

// File: tb/tb_c3aibadapt_cmn_clksel_ctrl.sv
// tb/tb_c3aibadapt_cmn_clksel_ctrl.sv - directed table-driven bench for the clock-select sequencer
module tb_c3aibadapt_cmn_clksel_ctrl;

  logic clk;
  logic rst;
  logic sel_req;
  logic clk_sel;
  logic clk_gate_en;
  logic sw_busy;
  logic sw_done;

  int checks;
  int errors;

  // Each row: cycle offset and expected {clk_sel, clk_gate_en, sw_busy, sw_done}.
  typedef struct {
    int       cyc;
    logic [3:0] exp;
  } vec_t;

  vec_t startup_tbl[6];
  vec_t switch_tbl[14];

  logic mon_en;
  logic prev_sel;
  logic prev_gate;
  int   viol_cnt;
  int   chg_cnt;
  int   done_cnt;

  c3aibadapt_cmn_clksel_ctrl #(
    .SYNC_STAGES (2),
    .GATE_CYC    (4),
    .SETTLE_CYC  (4),
    .RST_SEL     (1'b0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sel_req     (sel_req),
    .clk_sel     (clk_sel),
    .clk_gate_en (clk_gate_en),
    .sw_busy     (sw_busy),
    .sw_done     (sw_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en) begin
      if (clk_sel != prev_sel) begin
        chg_cnt = chg_cnt + 1;
        if (prev_gate) viol_cnt = viol_cnt + 1;
        if (clk_gate_en && !prev_gate) viol_cnt = viol_cnt + 1;
      end
      if (sw_done) done_cnt = done_cnt + 1;
      prev_sel  = clk_sel;
      prev_gate = clk_gate_en;
    end
  end

  function automatic logic [3:0] obs();
    return {clk_sel, clk_gate_en, sw_busy, sw_done};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic run_startup(input string tag);
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("%s_c%0d", tag, startup_tbl[i].cyc), int'(obs()), int'(startup_tbl[i].exp));
    end
  endtask

  initial begin
    int pulses;
    int bad;
    checks   = 0;
    errors   = 0;
    mon_en   = 1'b0;
    viol_cnt = 0;
    chg_cnt  = 0;
    done_cnt = 0;
    prev_sel  = 1'b0;
    prev_gate = 1'b0;

    startup_tbl[0] = '{1, 4'b0010};
    startup_tbl[1] = '{2, 4'b0010};
    startup_tbl[2] = '{3, 4'b0010};
    startup_tbl[3] = '{4, 4'b0010};
    startup_tbl[4] = '{5, 4'b0111};
    startup_tbl[5] = '{6, 4'b0100};

    switch_tbl[0]  = '{1,  4'b0100};
    switch_tbl[1]  = '{2,  4'b0100};
    switch_tbl[2]  = '{3,  4'b0010};
    switch_tbl[3]  = '{4,  4'b0010};
    switch_tbl[4]  = '{5,  4'b0010};
    switch_tbl[5]  = '{6,  4'b0010};
    switch_tbl[6]  = '{7,  4'b1010};
    switch_tbl[7]  = '{8,  4'b1010};
    switch_tbl[8]  = '{9,  4'b1010};
    switch_tbl[9]  = '{10, 4'b1010};
    switch_tbl[10] = '{11, 4'b1010};
    switch_tbl[11] = '{12, 4'b1010};
    switch_tbl[12] = '{13, 4'b1111};
    switch_tbl[13] = '{14, 4'b1100};

    // Test 1: reset values, then startup sequence
    rst = 1'b1;
    sel_req = 1'b0;
    step();
    step();
    chk("reset_outputs", int'(obs()), 4'b0010);
    rst = 1'b0;
    run_startup("startup");

    // Test 2: raise sel_req from IDLE
    sel_req = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step();
      chk($sformatf("switch01_c%0d", switch_tbl[i].cyc), int'(obs()), int'(switch_tbl[i].exp));
    end
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (obs() != 4'b1100) bad = bad + 1;
    end
    chk("hold_quiet_bad_cycles", bad, 0);

    // Return to clk_sel=0
    sel_req = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("return_to_0", int'(obs()), 4'b0100);

    // Test 3: 3-cycle pulse that reverts during GATE_OFF
    sel_req = 1'b1;
    pulses = 0;
    for (int c = 1; c <= 32; c++) begin
      step();
      if (c == 3) sel_req = 1'b0;
      if (sw_done) pulses = pulses + 1;
      if (c == 13) chk("glitch_first_done", int'(obs()), 4'b1111);
      if (c == 14) chk("glitch_restart", int'(obs()), 4'b1010);
      if (c == 18) chk("glitch_toggle_back", int'(obs()), 4'b0010);
      if (c == 24) chk("glitch_second_done", int'(obs()), 4'b0111);
    end
    chk("glitch_done_pulses", pulses, 2);
    chk("glitch_final", int'(obs()), 4'b0100);

    // Test 4: reset while in SETTLE with clk_sel=1
    sel_req = 1'b1;
    for (int i = 0; i < 9; i++) step();
    chk("settle_before_rst", int'(obs()), 4'b1010);
    rst = 1'b1;
    sel_req = 1'b0;
    step();
    chk("rst_in_settle", int'(obs()), 4'b0010);
    rst = 1'b0;
    run_startup("restart");

    // Test 5: random toggling with invariant monitor
    rst = 1'b1;
    step();
    step();
    prev_sel  = clk_sel;
    prev_gate = clk_gate_en;
    viol_cnt  = 0;
    chg_cnt   = 0;
    done_cnt  = 0;
    mon_en    = 1'b1;
    rst       = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      step();
      if ($urandom_range(0, 11) == 0) sel_req = ~sel_req;
    end
    for (int i = 0; i < 60; i++) step();
    mon_en = 1'b0;
    chk("rand_invariant_violations", viol_cnt, 0);
    chk("rand_done_vs_changes", done_cnt, chg_cnt + 1);
    chk("rand_final_sel", int'(clk_sel), int'(sel_req));
    chk("rand_final_idle", int'({clk_gate_en, sw_busy}), 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
